// File: rtl/seq_bin_to_bcd.sv
// seq_bin_to_bcd
// Sequential binary-to-BCD converter for the seven-segment display path.
// It takes a signed or unsigned binary word on a start strobe and forms
// its magnitude. It then runs a shift-and-add-3 (double-dabble) conversion,
// one bit per clock, and reports sign, DIGITS BCD digits and overflow.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   start     in   conversion request; ignored while a conversion runs
//   bin       in   [WIDTH-1:0] value to convert, sampled on accepted start
//   busy      out  high during the SHIFT cycles
//   done      out  one-cycle pulse when bcd/neg/overflow update
//   neg       out  sign of the last converted value (0 when SIGNED=0)
//   bcd       out  [4*DIGITS-1:0] last result, digit 0 = ones digit
//   overflow  out  last magnitude was >= 10^DIGITS
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// SHIFT  | one correct-and-shift step per cycle, WIDTH cycles in total
// DONE   | results published, done pulse; start accepted here as well

module seq_bin_to_bcd #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2,
    parameter int SIGNED = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [WIDTH-1:0]      r_shreg;
    logic [4*DIGITS-1:0]   r_work;
    logic [CW-1:0]         r_count;
    logic                  r_sign_pend;
    logic                  r_ovf_acc;

    logic                  w_accept;
    logic                  w_is_neg;
    logic [WIDTH-1:0]      w_mag;
    logic [4*DIGITS-1:0]   w_corr;
    logic [4*DIGITS-1:0]   w_work_nxt;
    logic                  w_out_bit;
    logic                  w_last_shift;

    assign w_accept     = start && (r_state != ST_SHIFT);
    assign w_last_shift = (r_state == ST_SHIFT) && (r_count == CW'(1));

    // Two's-complement negate wraps, so the most-negative input yields
    // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
    always_comb begin
        w_is_neg = (SIGNED != 0) && bin[WIDTH-1];
        w_mag    = bin;
        if (w_is_neg) begin
            w_mag = ~bin + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // All digits are corrected in parallel before the shift.
    always_comb begin
        w_corr = r_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_work[4*i +: 4] >= 4'd5) begin
                w_corr[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top digit is lost from the truncated register;
    // any such bit means the magnitude has reached 10^DIGITS.
    assign w_out_bit  = w_corr[4*DIGITS-1];
    assign w_work_nxt = {w_corr[4*DIGITS-2:0], r_shreg[WIDTH-1]};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last_shift) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = start ? ST_SHIFT : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode. This is a pure decode of the state register, so
    // there is no path from the inputs to the outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Working datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg     <= '0;
            r_work      <= '0;
            r_count     <= '0;
            r_sign_pend <= 1'b0;
            r_ovf_acc   <= 1'b0;
        end else if (w_accept) begin
            r_shreg     <= w_mag;
            r_work      <= '0;
            r_count     <= CW'(WIDTH);
            r_sign_pend <= w_is_neg;
            r_ovf_acc   <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            r_shreg     <= r_shreg << 1;
            r_work      <= w_work_nxt;
            r_count     <= r_count - CW'(1);
            r_ovf_acc   <= r_ovf_acc | w_out_bit;
        end
    end

    // Published results. They are taken from the final shift's next-values,
    // so they land on the same edge that enters DONE and hold until the
    // next DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd      <= '0;
            neg      <= 1'b0;
            overflow <= 1'b0;
        end else if (w_last_shift) begin
            bcd      <= w_work_nxt;
            neg      <= r_sign_pend;
            overflow <= r_ovf_acc | w_out_bit;
        end
    end

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
module tb_seq_bin_to_bcd;

    typedef struct packed {
        logic [7:0] bcd;
        logic       neg;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       start_a = 1'b0;
    logic [5:0] bin_a = '0;
    logic       busy_a, done_a, neg_a, ovf_a;
    logic [7:0] bcd_a;

    logic       start_b = 1'b0;
    logic [7:0] bin_b = '0;
    logic       busy_b, done_b, neg_b, ovf_b;
    logic [7:0] bcd_b;

    int   n_vec = 0;
    int   n_err = 0;
    int   dones_a = 0;
    int   dones_b = 0;
    int   pushed_a = 0;
    int   pushed_b = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    seq_bin_to_bcd #(.WIDTH(6), .DIGITS(2), .SIGNED(1)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .neg(neg_a), .bcd(bcd_a), .overflow(ovf_a)
    );

    seq_bin_to_bcd #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .neg(neg_b), .bcd(bcd_b), .overflow(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model_a(input logic [5:0] v);
        exp_t r;
        int   mag;
        mag   = v[5] ? (64 - int'(v)) : int'(v);
        r.bcd = {4'((mag / 10) % 10), 4'(mag % 10)};
        r.neg = v[5];
        r.ovf = (mag >= 100);
        return r;
    endfunction

    function automatic exp_t model_b(input logic [7:0] v);
        exp_t r;
        int   mag;
        mag   = int'(v);
        r.bcd = {4'((mag / 10) % 10), 4'(mag % 10)};
        r.neg = 1'b0;
        r.ovf = (mag >= 100);
        return r;
    endfunction

    // Scoreboards: results are popped and compared whenever done pulses.
    always @(negedge clk) begin
        if (done_a) begin
            exp_t e;
            dones_a++;
            chk("a_sb_pending", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_bcd", bcd_a, e.bcd);
                chk("a_neg", neg_a, e.neg);
                chk("a_ovf", ovf_a, e.ovf);
            end
        end
        if (done_b) begin
            exp_t e;
            dones_b++;
            chk("b_sb_pending", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_bcd", bcd_b, e.bcd);
                chk("b_neg", neg_b, e.neg);
                chk("b_ovf", ovf_b, e.ovf);
            end
        end
    end

    // Called just after a clock edge; leaves the bench in the DONE cycle so
    // that a following call restarts back-to-back.
    task automatic run_a(input logic [5:0] v, input exp_t e, input string tag);
        int k;
        int nb;
        start_a = 1'b1;
        bin_a   = v;
        qa.push_back(e);
        pushed_a++;
        k  = 0;
        nb = 0;
        do begin
            tick();
            k++;
            start_a = 1'b0;
            if (busy_a) nb++;
        end while (!done_a && k < 30);
        chk({tag, "_latency"}, k, 7);
        chk({tag, "_busy_cycles"}, nb, 6);
    endtask

    task automatic run_b(input logic [7:0] v, input exp_t e, input string tag);
        int k;
        int nb;
        start_b = 1'b1;
        bin_b   = v;
        qb.push_back(e);
        pushed_b++;
        k  = 0;
        nb = 0;
        do begin
            tick();
            k++;
            start_b = 1'b0;
            if (busy_b) nb++;
        end while (!done_b && k < 30);
        chk({tag, "_latency"}, k, 9);
        chk({tag, "_busy_cycles"}, nb, 8);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        // Reset state
        tick();
        tick();
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_bcd", bcd_a, 0);
        chk("rst_neg", neg_a, 0);
        chk("rst_ovf", ovf_a, 0);
        reset = 1'b0;
        tick();
        tick();

        // Positive value and signed extremes
        run_a(6'b011001, '{bcd: 8'h25, neg: 1'b0, ovf: 1'b0}, "a_pos25");
        tick();
        run_a(6'b100000, '{bcd: 8'h32, neg: 1'b1, ovf: 1'b0}, "a_min");
        tick();
        run_a(6'b111111, '{bcd: 8'h01, neg: 1'b1, ovf: 1'b0}, "a_m1");
        tick();
        run_a(6'b011111, '{bcd: 8'h31, neg: 1'b0, ovf: 1'b0}, "a_max");
        tick();
        chk("a_hold_bcd", bcd_a, 8'h31);

        // Start while busy is ignored
        start_a = 1'b1;
        bin_a   = 6'd25;
        qa.push_back('{bcd: 8'h25, neg: 1'b0, ovf: 1'b0});
        pushed_a++;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        start_a = 1'b1;
        bin_a   = 6'd9;
        tick();
        start_a = 1'b0;
        k = 0;
        while (!done_a && k < 30) begin
            tick();
            k++;
        end
        chk("a_ignore_done_seen", done_a, 1);
        repeat (10) tick();
        chk("a_ignore_done_count", dones_a, pushed_a);
        run_a(6'd9, '{bcd: 8'h09, neg: 1'b0, ovf: 1'b0}, "a_nine");

        // Back-to-back: restart in the DONE cycle
        tick();
        run_a(6'd25, '{bcd: 8'h25, neg: 1'b0, ovf: 1'b0}, "a_b2b_first");
        run_a(6'b110110, '{bcd: 8'h10, neg: 1'b1, ovf: 1'b0}, "a_b2b_second");
        tick();
        chk("a_b2b_done_count", dones_a, pushed_a);

        // Reset in the 3rd SHIFT cycle
        start_a = 1'b1;
        bin_a   = 6'd20;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        chk("a_mid_busy_before", busy_a, 1);
        reset = 1'b1;
        #1;
        chk("a_mid_busy", busy_a, 0);
        chk("a_mid_done", done_a, 0);
        chk("a_mid_bcd", bcd_a, 0);
        chk("a_mid_neg", neg_a, 0);
        chk("a_mid_ovf", ovf_a, 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (12) tick();
        chk("a_mid_no_done", dones_a, pushed_a);
        run_a(6'b101011, '{bcd: 8'h21, neg: 1'b1, ovf: 1'b0}, "a_after_rst");

        // Full back-to-back sweep of the signed range
        for (int v = 0; v < 64; v++) begin
            run_a(6'(v), model_a(6'(v)), "a_sweep");
        end
        tick();
        tick();

        // Unsigned, WIDTH=8: overflow truncates modulo 100
        run_b(8'd255, '{bcd: 8'h55, neg: 1'b0, ovf: 1'b1}, "b_255");
        tick();
        run_b(8'd99, '{bcd: 8'h99, neg: 1'b0, ovf: 1'b0}, "b_99");
        run_b(8'd100, '{bcd: 8'h00, neg: 1'b0, ovf: 1'b1}, "b_100");
        for (int v = 0; v < 256; v++) begin
            run_b(8'(v), model_b(8'(v)), "b_sweep");
        end
        repeat (4) tick();

        chk("a_total_dones", dones_a, pushed_a);
        chk("b_total_dones", dones_b, pushed_b);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
